// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit.
//   SIZE_* : request size codes (byte, half, word, reserved)
//   state_t: access FSM states
//   req_t  : latched request payload
package mem_access_pkg;

  localparam int unsigned MEM_BYTES_DEF = 2048;
  localparam int unsigned DATA_W        = 32;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // Only the lane bits of the address are kept; the word address lives in the mem_addr register.
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte/half lane handling for the memory access unit.
//   i_rdata   : word read from memory
//   i_wdata   : right-aligned store data
//   i_lane    : byte address bits [1:0]
//   i_size    : access size code
//   i_signed  : sign-extend sub-word loads
//   o_load_c  : extracted and extended load value
//   o_merge_c : i_rdata with the addressed lane replaced by i_wdata
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_load_c,
  output logic [DATA_W-1:0] o_merge_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_shift;

  assign w_shift = {i_lane, 3'b000};
  assign w_byte  = i_rdata[w_shift +: 8];
  assign w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Load extraction with sign/zero extension from the lane's top bit.
  always_comb begin
    o_load_c = i_rdata;
    case (i_size)
      SIZE_B:  o_load_c = {{24{i_signed & w_byte[7]}}, w_byte};
      SIZE_H:  o_load_c = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_c = i_rdata;
    endcase
  end

  // Store merge: addressed lane from store data, other lanes preserved.
  always_comb begin
    o_merge_c = i_rdata;
    case (i_size)
      SIZE_B: o_merge_c[w_shift +: 8] = i_wdata[7:0];
      SIZE_H: begin
        if (i_lane[1]) o_merge_c[31:16] = i_wdata[15:0];
        else           o_merge_c[15:0]  = i_wdata[15:0];
      end
      SIZE_W:  o_merge_c = i_wdata;
      default: o_merge_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: one load/store per accept, single-cycle response.
//   clk, reset           : clock, async active-high reset
//   i_req_*/o_req_ready  : request from MEM stage (accept = valid & ready)
//   o_resp_*             : one-cycle response pulse with error flag and load data
//   o_mem_*/i_mem_rdata  : word-addressed data memory, combinational read, posedge write
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic              o_resp_err,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t            r_state, w_nxt_state;
  req_t              r_req, w_nxt_req;
  logic              w_nxt_ready, w_nxt_resp_valid, w_nxt_resp_err;
  logic [DATA_W-1:0] w_nxt_resp_rdata, w_nxt_mem_wdata;
  logic [ADDR_W-1:0] w_nxt_mem_addr, w_word_addr;
  logic              w_nxt_mem_rd, w_nxt_mem_wr;
  logic              w_accept, w_err;
  logic [DATA_W-1:0] w_load_val, w_merge_val;

  assign w_accept    = i_req_valid & o_req_ready;
  assign w_word_addr = {i_req_addr[ADDR_W-1:2], 2'b00};

  // Request-time error classification; a failing request never touches memory.
  assign w_err = (i_req_size == SIZE_RSV)
               | ((i_req_size == SIZE_H) & i_req_addr[0])
               | ((i_req_size == SIZE_W) & (i_req_addr[1:0] != 2'b00))
               | (i_req_addr >= ADDR_W'(MEM_BYTES));

  mem_lane_align u_align (
    .i_rdata   (i_mem_rdata),
    .i_wdata   (r_req.wdata),
    .i_lane    (r_req.lane),
    .i_size    (r_req.size),
    .i_signed  (r_req.sgn),
    .o_load_c  (w_load_val),
    .o_merge_c (w_merge_val)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_req        = r_req;
    w_nxt_ready      = 1'b0;
    w_nxt_resp_valid = 1'b0;
    w_nxt_resp_err   = 1'b0;
    w_nxt_resp_rdata = '0;
    w_nxt_mem_addr   = '0;
    w_nxt_mem_rd     = 1'b0;
    w_nxt_mem_wr     = 1'b0;
    w_nxt_mem_wdata  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nxt_req.wr    = i_req_wr;
          w_nxt_req.size  = i_req_size;
          w_nxt_req.sgn   = i_req_signed;
          w_nxt_req.lane  = i_req_addr[1:0];
          w_nxt_req.wdata = i_req_wdata;
          if (w_err) begin
            w_nxt_state      = RESP;
            w_nxt_resp_valid = 1'b1;
            w_nxt_resp_err   = 1'b1;
          end else if (!i_req_wr) begin
            w_nxt_state    = LOAD;
            w_nxt_mem_addr = w_word_addr;
            w_nxt_mem_rd   = 1'b1;
          end else if (i_req_size == SIZE_W) begin
            w_nxt_state     = WRITE;
            w_nxt_mem_addr  = w_word_addr;
            w_nxt_mem_wr    = 1'b1;
            w_nxt_mem_wdata = i_req_wdata;
          end else begin
            w_nxt_state    = RMW_RD;
            w_nxt_mem_addr = w_word_addr;
            w_nxt_mem_rd   = 1'b1;
          end
        end else begin
          w_nxt_ready = 1'b1;
        end
      end
      LOAD: begin
        w_nxt_state      = RESP;
        w_nxt_resp_valid = 1'b1;
        w_nxt_resp_rdata = w_load_val;
      end
      RMW_RD: begin
        w_nxt_state     = WRITE;
        w_nxt_mem_addr  = o_mem_addr;
        w_nxt_mem_wr    = 1'b1;
        w_nxt_mem_wdata = w_merge_val;
      end
      WRITE: begin
        w_nxt_state      = RESP;
        w_nxt_resp_valid = 1'b1;
      end
      RESP: begin
        w_nxt_state = IDLE;
        w_nxt_ready = 1'b1;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_ready = 1'b1;
      end
    endcase
  end

  // State, request latch and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req        <= '0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_err   <= 1'b0;
      o_resp_rdata <= '0;
      o_mem_addr   <= '0;
      o_mem_rd     <= 1'b0;
      o_mem_wr     <= 1'b0;
      o_mem_wdata  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_req        <= w_nxt_req;
      o_req_ready  <= w_nxt_ready;
      o_resp_valid <= w_nxt_resp_valid;
      o_resp_err   <= w_nxt_resp_err;
      o_resp_rdata <= w_nxt_resp_rdata;
      o_mem_addr   <= w_nxt_mem_addr;
      o_mem_rd     <= w_nxt_mem_rd;
      o_mem_wr     <= w_nxt_mem_wr;
      o_mem_wdata  <= w_nxt_mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word-addressed memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_wr, i_req_signed;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata, w_mem_rdata;
  logic        o_mem_rd, o_mem_wr;

  logic [31:0] mem [0:511];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(2048), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_wr     (i_req_wr),
    .i_req_size   (i_req_size),
    .i_req_signed (i_req_signed),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_err   (o_resp_err),
    .o_resp_rdata (o_resp_rdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rd     (o_mem_rd),
    .o_mem_wr     (o_mem_wr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (w_mem_rdata)
  );

  assign w_mem_rdata = o_mem_rd ? mem[o_mem_addr[10:2]] : 32'h0;

  always @(posedge clk) begin
    if (o_mem_wr) mem[o_mem_addr[10:2]] <= o_mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request and follows it to its response, recording memory activity.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rd_cnt, output int wr_cnt,
                        output logic [31:0] wdata_seen, output logic [31:0] addr_seen);
    int guard;
    bit done;
    rdata = '0; err = 1'b0; lat = 0; rd_cnt = 0; wr_cnt = 0;
    wdata_seen = '0; addr_seen = '0; done = 1'b0; guard = 0;
    @(negedge clk);
    i_req_wr = wr; i_req_size = sz; i_req_signed = sg;
    i_req_addr = addr; i_req_wdata = wd; i_req_valid = 1'b1;
    while (!o_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      i_req_valid = 1'b0;
    end else begin
      // Busy-time changes must not disturb the accepted request.
      i_req_addr  = 32'h0000_0010;
      i_req_wdata = ~wd;
      i_req_wr    = ~wr;
    end
    lat = 1;
    while (!done && lat < 10) begin
      chk("rd_wr_excl", 32'(o_mem_rd & o_mem_wr), 32'd0);
      if (hold) chk("busy_ready", 32'(o_req_ready), 32'd0);
      if (o_mem_rd) begin rd_cnt++; addr_seen = o_mem_addr; end
      if (o_mem_wr) begin wr_cnt++; wdata_seen = o_mem_wdata; addr_seen = o_mem_addr; end
      if (o_resp_valid) begin
        rdata = o_resp_rdata;
        err   = o_resp_err;
        done  = 1'b1;
        chk("resp_mem_addr", o_mem_addr, 32'h0);
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk("resp_seen", 32'(done), 32'd1);
    i_req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("resp_pulse", 32'(o_resp_valid), 32'd0);
    chk("ready_back", 32'(o_req_ready), 32'd1);
  endtask

  logic [31:0] rd, wds, ads;
  logic        er;
  int          lt, nr, nw;
  bit          saw_resp;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0] = 32'h80FF_7F05;
    mem[3] = 32'h0000_000C;
    reset = 1'b1;
    i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_size = 2'b00; i_req_signed = 1'b0;
    i_req_addr = '0; i_req_wdata = '0;
    #12;
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_mem_rd", 32'(o_mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(o_mem_wr), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_rdata", o_resp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Sub-word and word loads.
    do_req(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lb2_data", rd, 32'hFFFF_FFFF); chk("lb2_err", 32'(er), 32'd0);
    chk("lb2_lat", 32'(lt), 32'd2);     chk("lb2_addr", ads, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lb1_data", rd, 32'h0000_007F);
    do_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lbu3_data", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lh2_data", rd, 32'hFFFF_80FF); chk("lh2_wr", 32'(nw), 32'd0);
    do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lhu2_data", rd, 32'h0000_80FF);
    do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lw_c_data", rd, 32'h0000_000C); chk("lw_c_wr", 32'(nw), 32'd0);
    chk("lw_c_rd", 32'(nr), 32'd1);      chk("lw_c_addr", ads, 32'h0000_000C);

    // Byte store via read-modify-write.
    do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h0000_00AB, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("sb_lat", 32'(lt), 32'd3);   chk("sb_rd", 32'(nr), 32'd1);
    chk("sb_wr", 32'(nw), 32'd1);    chk("sb_wdata", wds, 32'h80AB_7F05);
    chk("sb_rdata", rd, 32'h0);      chk("sb_err", 32'(er), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lw0_after_sb", rd, 32'h80AB_7F05);
    do_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("sh_wdata", wds, 32'hBEEF_7F05);

    // Error cases: one-cycle response, no memory activity.
    do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'h1, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("sh5_err", 32'(er), 32'd1);  chk("sh5_lat", 32'(lt), 32'd1);
    chk("sh5_mem", 32'(nr + nw), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lw6_err", 32'(er), 32'd1);  chk("lw6_rdata", rd, 32'h0);
    chk("lw6_mem", 32'(nr + nw), 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("rsv_err", 32'(er), 32'd1);  chk("rsv_lat", 32'(lt), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("oor_err", 32'(er), 32'd1);  chk("oor_mem", 32'(nr + nw), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("last_word_err", 32'(er), 32'd0);

    // Held request while busy, then back-to-back store/load.
    do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 1'b1, rd, er, lt, nr, nw, wds, ads);
    chk("hold_data", rd, 32'h0000_000C); chk("hold_lat", 32'(lt), 32'd2);
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("sw_lat", 32'(lt), 32'd2);   chk("sw_rd", 32'(nr), 32'd0);
    chk("sw_wdata", wds, 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, lt, nr, nw, wds, ads);
    chk("lw4_data", rd, 32'h1234_5678);

    // Reset asserted while a word store is in WRITE.
    @(negedge clk);
    i_req_wr = 1'b1; i_req_size = 2'b10; i_req_signed = 1'b0;
    i_req_addr = 32'h14; i_req_wdata = 32'hDEAD_BEEF; i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    chk("rst_pre_wr", 32'(o_mem_wr), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr_drop", 32'(o_mem_wr), 32'd0);
    chk("rst_ready_idle", 32'(o_req_ready), 32'd1);
    chk("rst_no_resp", 32'(o_resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (o_resp_valid) saw_resp = 1'b1;
    end
    chk("rst_resp_none", 32'(saw_resp), 32'd0);
    chk("rst_word_kept", mem[5], 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
